bsg_fsb_echo_client: RTL and testbench

// - Client-side (ASIC) responder for the master test nodes driven by bsg_guts on the gateway.
// - Accepts ring packets arriving from the master, buffers them, and returns each one unchanged.
// - Counts echoed packets and raises done_o after iterations_p returns; the gateway's done

---
 rtl/bsg_fsb_echo_client_pkg.sv | 14 +
 rtl/bsg_fsb_echo_client_buf.sv | 46 ++++
 rtl/bsg_fsb_echo_client.sv | 100 ++++++++++
 tb/tb_bsg_fsb_echo_client.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_fsb_echo_client_pkg.sv
// Shared types and constants for the FSB echo client node.
package bsg_fsb_echo_client_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    localparam int ring_bytes_gp = 10;
    localparam int seq_byte_gp   = 0;

endpackage

// File: rtl/bsg_fsb_echo_client_buf.sv
// Circular echo buffer: enqueue side gated by full, dequeue side gated by empty.
module bsg_fsb_echo_client_buf #(
    parameter int width_p = 80,
    parameter int els_p   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enq,
    input  logic [width_p-1:0] enq_data,
    input  logic               deq,
    output logic [width_p-1:0] deq_data,
    output logic               full,
    output logic               empty
);

    localparam int ptr_w = $clog2(els_p);

    // MSB of each pointer is the wrap flag separating full from empty
    logic [ptr_w:0]       wr_ptr;
    logic [ptr_w:0]       rd_ptr;
    logic [width_p-1:0]   mem [els_p];
    logic                 do_enq;
    logic                 do_deq;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[ptr_w-1:0] == rd_ptr[ptr_w-1:0]) && (wr_ptr[ptr_w] != rd_ptr[ptr_w]);
    assign do_enq = enq && !full;
    assign do_deq = deq && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_enq) wr_ptr <= wr_ptr + 1'b1;
            if (do_deq) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) mem[wr_ptr[ptr_w-1:0]] <= enq_data;
    end

    assign deq_data = empty ? '0 : mem[rd_ptr[ptr_w-1:0]];

endmodule

// File: rtl/bsg_fsb_echo_client.sv
// Echo client node: buffers inbound ring packets and returns them unchanged.
// Optional byte-0 sequence checker enabled by BSG_FSB_ECHO_CLIENT_SEQ_CHECK_EN.
module bsg_fsb_echo_client
    import bsg_fsb_echo_client_pkg::*;
#(
    parameter int ring_width_p = 80,
    parameter int fifo_els_p   = 4,
    parameter int iterations_p = 16
) (
    input  logic                              core_clk_i,
    input  logic                              async_reset_i,
    input  logic                              en_i,
    input  logic                              v_i,
    input  logic [ring_width_p-1:0]           data_i,
    output logic                              ready_o,
    output logic                              v_o,
    output logic [ring_width_p-1:0]           data_o,
    input  logic                              yumi_i,
    output logic                              done_o,
    output logic [$clog2(iterations_p+1)-1:0] pkt_count_o,
    output logic                              error_o
);

    localparam int cnt_w = $clog2(iterations_p+1);
    localparam logic [cnt_w-1:0] last_rx  = cnt_w'(iterations_p - 1);
    localparam logic [cnt_w-1:0] iter_max = cnt_w'(iterations_p);

    state_e                  state;
    logic [cnt_w-1:0]        rx_cnt;
    logic [cnt_w-1:0]        pkt_count;
    logic                    full;
    logic                    empty;
    logic                    accept;
    logic                    echo;
    logic [ring_width_p-1:0] buf_data;

    assign ready_o     = (state == RUN) && en_i && !full;
    assign accept      = v_i && ready_o;
    assign v_o         = !empty && (state != DONE);
    assign echo        = v_o && yumi_i;
    assign data_o      = v_o ? buf_data : '0;
    assign done_o      = (state == DONE);
    assign pkt_count_o = pkt_count;

    bsg_fsb_echo_client_buf #(
        .width_p (ring_width_p),
        .els_p   (fifo_els_p)
    ) echo_buf (
        .clk      (core_clk_i),
        .rst      (async_reset_i),
        .enq      (accept),
        .enq_data (data_i),
        .deq      (echo),
        .deq_data (buf_data),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge core_clk_i or posedge async_reset_i) begin
        if (async_reset_i) begin
            state     <= IDLE;
            rx_cnt    <= '0;
            pkt_count <= '0;
        end else begin
            if (accept) rx_cnt <= rx_cnt + 1'b1;
            if (echo && pkt_count != iter_max) pkt_count <= pkt_count + 1'b1;
            case (state)
                IDLE:    if (en_i) state <= RUN;
                // en_i low with data still buffered keeps draining here
                RUN: begin
                    if (accept && rx_cnt == last_rx) state <= DRAIN;
                    else if (!en_i && empty)         state <= IDLE;
                end
                DRAIN:   if (echo && pkt_count == iter_max - 1'b1) state <= DONE;
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BSG_FSB_ECHO_CLIENT_SEQ_CHECK_EN
    logic [7:0] expected_seq;
    logic       seq_error;

    always_ff @(posedge core_clk_i or posedge async_reset_i) begin
        if (async_reset_i) begin
            expected_seq <= '0;
            seq_error    <= 1'b0;
        end else if (accept) begin
            expected_seq <= expected_seq + 8'd1;
            if (data_i[seq_byte_gp*8 +: 8] != expected_seq) seq_error <= 1'b1;
        end
    end

    assign error_o = seq_error;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_fsb_echo_client.sv
// Self-checking bench for bsg_fsb_echo_client (default parameters).
module tb_bsg_fsb_echo_client;

    localparam int W     = 80;
    localparam int DEPTH = 4;
    localparam int ITER  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          v;
    logic [W-1:0]  d;
    logic          yumi;
    logic          ready_o;
    logic          v_o;
    logic [W-1:0]  data_o;
    logic          done_o;
    logic [4:0]    pkt_count_o;
    logic          error_o;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: phase 0 idle, 1 running, 2 draining, 3 finished
    int            m_phase;
    logic [W-1:0]  mq[$];
    int            m_rx;
    int            m_tx;
    bit            m_err;
    int            m_seq;

    typedef struct {
        bit           en;
        bit           v;
        bit           yumi;
        logic [W-1:0] d;
        bit           e_ready;
        bit           e_v;
        logic [W-1:0] e_data;
        int           e_cnt;
    } vec_t;

    vec_t tbl[13];

    always #5 clk = ~clk;

    bsg_fsb_echo_client #(
        .ring_width_p (W),
        .fifo_els_p   (DEPTH),
        .iterations_p (ITER)
    ) dut (
        .core_clk_i    (clk),
        .async_reset_i (rst),
        .en_i          (en),
        .v_i           (v),
        .data_i        (d),
        .ready_o       (ready_o),
        .v_o           (v_o),
        .data_o        (data_o),
        .yumi_i        (yumi),
        .done_o        (done_o),
        .pkt_count_o   (pkt_count_o),
        .error_o       (error_o)
    );

    function automatic logic [W-1:0] pk(input int s);
        logic [71:0] body;
        body = 72'h5A_0123_4567_89AB_CDEF ^ 72'(s * 7919);
        return {body, 8'(s)};
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        mq.delete();
        m_rx  = 0;
        m_tx  = 0;
        m_err = 1'b0;
        m_seq = 0;
    endtask

    // Called at the negedge: compare DUT to model, then advance model over the posedge.
    task automatic model_step();
        bit e_ready, e_v, acc, dq, pre_empty;
        e_ready = (m_phase == 1) && en && (mq.size() < DEPTH);
        e_v     = (m_phase != 3) && (mq.size() > 0);
        chk("ready", W'(ready_o), W'(e_ready));
        chk("v_o", W'(v_o), W'(e_v));
        if (e_v) chk("data_o", data_o, mq[0]);
        chk("done", W'(done_o), W'(m_phase == 3));
        chk("pkt_count", W'(pkt_count_o), W'(m_tx));
        chk("error", W'(error_o), W'(m_err));
        acc = v && e_ready;
        dq  = yumi && e_v;
        @(posedge clk);
        pre_empty = (mq.size() == 0);
        if (dq) begin
            void'(mq.pop_front());
            if (m_tx < ITER) m_tx++;
        end
        if (acc) begin
            mq.push_back(d);
            m_rx++;
`ifdef BSG_FSB_ECHO_CLIENT_SEQ_CHECK_EN
            if (d[7:0] != 8'(m_seq)) m_err = 1'b1;
`endif
            m_seq = (m_seq + 1) % 256;
        end
        case (m_phase)
            0: if (en) m_phase = 1;
            1: begin
                if (acc && m_rx == ITER)   m_phase = 2;
                else if (!en && pre_empty) m_phase = 0;
            end
            2: if (dq && m_tx == ITER) m_phase = 3;
            default: ;
        endcase
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
    endtask

    task automatic drive(input bit e, input bit vv, input logic [W-1:0] dd, input bit y);
        en = e; v = vv; d = dd; yumi = y;
    endtask

    task automatic do_reset();
        drive(0, 0, '0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        drive(0, 0, '0, 0);
        model_reset();

        // directed vectors: single echo, then fill to full with a 5th pending packet
        tbl[0]  = '{0, 0, 0, '0,    0, 0, '0,    0};
        tbl[1]  = '{1, 0, 0, '0,    0, 0, '0,    0};
        tbl[2]  = '{1, 1, 0, pk(0), 1, 0, '0,    0};
        tbl[3]  = '{1, 0, 0, '0,    1, 1, pk(0), 0};
        tbl[4]  = '{1, 0, 1, '0,    1, 1, pk(0), 0};
        tbl[5]  = '{1, 1, 0, pk(1), 1, 0, '0,    1};
        tbl[6]  = '{1, 1, 0, pk(2), 1, 1, pk(1), 1};
        tbl[7]  = '{1, 1, 0, pk(3), 1, 1, pk(1), 1};
        tbl[8]  = '{1, 1, 0, pk(4), 1, 1, pk(1), 1};
        tbl[9]  = '{1, 1, 0, pk(5), 0, 1, pk(1), 1};
        tbl[10] = '{1, 1, 1, pk(5), 0, 1, pk(1), 1};
        tbl[11] = '{1, 1, 0, pk(5), 1, 1, pk(2), 2};
        tbl[12] = '{1, 0, 0, '0,    0, 1, pk(2), 2};

        #12;
        chk("rst_ready", W'(ready_o), '0);
        chk("rst_v_o", W'(v_o), '0);
        chk("rst_data_o", data_o, '0);
        chk("rst_done", W'(done_o), '0);
        chk("rst_pkt_count", W'(pkt_count_o), '0);
        chk("rst_error", W'(error_o), '0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].en, tbl[i].v, tbl[i].d, tbl[i].yumi);
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", i), W'(ready_o), W'(tbl[i].e_ready));
            chk($sformatf("tbl%0d_v_o", i), W'(v_o), W'(tbl[i].e_v));
            if (tbl[i].e_v) chk($sformatf("tbl%0d_data", i), data_o, tbl[i].e_data);
            chk($sformatf("tbl%0d_cnt", i), W'(pkt_count_o), W'(tbl[i].e_cnt));
            model_step();
        end

        // one more echo leaves 3 buffered, then reset mid-operation
        drive(1, 0, '0, 1);
        tick();
        drive(0, 0, '0, 0);
        rst = 1'b1;
        #1;
        chk("midrst_v_o", W'(v_o), '0);
        chk("midrst_pkt_count", W'(pkt_count_o), '0);
        chk("midrst_ready", W'(ready_o), '0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, '0, i == 1);
            tick();
        end
        drive(1, 0, '0, 0);
        @(negedge clk);
        chk("postrst_idle_ready", W'(ready_o), '0);
        model_step();

        // en_i dropped with 2 packets buffered
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, pk(i), 0);
            tick();
        end
        drive(0, 1, pk(2), 0);
        @(negedge clk);
        chk("endrop_ready", W'(ready_o), '0);
        model_step();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, pk(2), mq.size() > 0);
            tick();
        end
        drive(1, 0, '0, 0);
        @(negedge clk);
        chk("resume_idle_ready", W'(ready_o), '0);
        model_step();
        @(negedge clk);
        chk("resume_run_ready", W'(ready_o), 80'd1);
        model_step();

        // sequence checker: byte 0 sequence 0,1,3
        do_reset();
        drive(1, 0, '0, 0);
        tick();
        drive(1, 1, pk(0), 0); tick();
        drive(1, 1, pk(1), 0); tick();
        drive(1, 1, pk(3), 0); tick();
        drive(1, 0, '0, 0);
        @(negedge clk);
`ifdef BSG_FSB_ECHO_CLIENT_SEQ_CHECK_EN
        chk("seq_error", W'(error_o), 80'd1);
`else
        chk("seq_error", W'(error_o), '0);
`endif
        model_step();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, '0, mq.size() > 0);
            tick();
        end

        // full run of ITER packets with random valid and yumi
        do_reset();
        cyc = 0;
        while (m_phase != 3 && cyc < 800) begin
            drive(1, $urandom_range(0, 3) != 0, {$urandom, $urandom, 8'($urandom), 8'(m_seq)},
                  (mq.size() > 0) && ($urandom_range(0, 1) == 1));
            tick();
            cyc++;
        end
        drive(1, 1, pk(99), 0);
        @(negedge clk);
        chk("final_done", W'(done_o), 80'd1);
        chk("final_pkt_count", W'(pkt_count_o), 80'(ITER));
        chk("final_ready", W'(ready_o), '0);
        chk("final_v_o", W'(v_o), '0);
        model_step();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, pk(100 + i), 1'b0);
            tick();
        end
        chk("no_extra_accept", W'(pkt_count_o), 80'(ITER));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
